// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath controller and its instruction decoder.
// Build option: DATAPATH_CTRL_ILLEGAL_TRAP_EN adds the HALT state for illegal instructions.
package datapath_ctrl_pkg;

    typedef enum logic [2:0] {
        StWait,
        StDecode,
        StWriteImm,
        StGetA,
        StGetB,
        StAlu,
        StWriteReg
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
        , StHalt
`endif
    } state_e;

    typedef enum logic [2:0] {
        ClsMovImm,
        ClsMovReg,
        ClsAdd,
        ClsCmp,
        ClsAnd,
        ClsMvn,
        ClsNone
    } instr_class_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    function automatic logic [15:0] sext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into fields and an instruction class.
module instr_decoder
    import datapath_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  cls,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [1:0]  op,
    output logic [15:0] sximm8,
    output logic        illegal
);

    instr_class_e cls_e;

    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign op     = ir[12:11];
    assign sximm8 = sext8(ir[7:0]);
    assign cls    = cls_e;

    always_comb begin
        cls_e   = ClsNone;
        illegal = 1'b0;
        unique case ({ir[15:13], ir[12:11]})
            {OPC_MOV, OP_MOV_IMM}: cls_e = ClsMovImm;
            {OPC_MOV, OP_MOV_REG}: cls_e = ClsMovReg;
            {OPC_ALU, OP_ADD}:     cls_e = ClsAdd;
            {OPC_ALU, OP_CMP}:     cls_e = ClsCmp;
            {OPC_ALU, OP_AND}:     cls_e = ClsAnd;
            {OPC_ALU, OP_MVN}:     cls_e = ClsMvn;
            default:               illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Instruction-sequencing FSM driving the register file, pipeline registers, shifter and ALU.
// Build option: DATAPATH_CTRL_ILLEGAL_TRAP_EN traps illegal instructions in HALT (err=1).
module datapath_controller
    import datapath_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8,
    output logic        err
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0]  dec_cls;
    logic [2:0]  dec_rn, dec_rd, dec_rm;
    logic [1:0]  dec_sh, dec_op;
    logic        dec_illegal;

    instr_decoder u_decoder (
        .ir      (ir_q),
        .cls     (dec_cls),
        .rn      (dec_rn),
        .rd      (dec_rd),
        .rm      (dec_rm),
        .sh      (dec_sh),
        .op      (dec_op),
        .sximm8  (sximm8),
        .illegal (dec_illegal)
    );

    // Async reset clears the state, so every Moore strobe drops without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StWait;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = VSEL_C;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        aluop    = ALU_ADD;
        err      = 1'b0;

        case (state_q)
            StWait: begin
                w = 1'b1;
                if (s) begin
                    ir_d    = in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_illegal) begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
                    state_d = StHalt;
`else
                    state_d = StWait;
`endif
                end else begin
                    case (dec_cls)
                        ClsMovImm:              state_d = StWriteImm;
                        ClsAdd, ClsCmp, ClsAnd: state_d = StGetA;
                        default:                state_d = StGetB;
                    endcase
                end
            end
            StWriteImm: begin
                writenum = dec_rn;
                vsel     = VSEL_IMM;
                write    = 1'b1;
                state_d  = StWait;
            end
            StGetA: begin
                readnum = dec_rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = dec_rm;
                loadb   = 1'b1;
                state_d = StAlu;
            end
            StAlu: begin
                shift = dec_sh;
                aluop = (dec_cls == ClsMovReg) ? ALU_ADD : dec_op;
                // Single-operand forms pass B through with A zeroed.
                asel  = (dec_cls == ClsMovReg) || (dec_cls == ClsMvn);
                if (dec_cls == ClsCmp) begin
                    loads   = 1'b1;
                    state_d = StWait;
                end else begin
                    loadc   = 1'b1;
                    state_d = StWriteReg;
                end
            end
            StWriteReg: begin
                writenum = dec_rd;
                vsel     = VSEL_C;
                write    = 1'b1;
                state_d  = StWait;
            end
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
            StHalt: begin
                err     = 1'b1;
                state_d = StHalt;
            end
`endif
            default: state_d = StWait;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench: directed and random instructions compared per cycle against a trace model.
module tb_datapath_controller;

    logic        clk, reset, s;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, err;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8;

    typedef struct packed {
        logic        w;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic        write;
        logic [1:0]  vsel;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] sximm8;
        logic        err;
    } out_t;

    out_t obs;
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] cur_sx;
    logic [15:0] rnd[41];

    datapath_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .in       (in),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .aluop    (aluop),
        .sximm8   (sximm8),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb obs = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel,
                       shift, aluop, sximm8, err};

    function automatic out_t blank(input logic [15:0] sx);
        out_t o;
        o = '0;
        o.sximm8 = sx;
        return o;
    endfunction

    function automatic out_t idle(input logic [15:0] sx);
        out_t o;
        o = blank(sx);
        o.w = 1'b1;
        return o;
    endfunction

    function automatic bit is_legal(input logic [15:0] i);
        return (i[15:13] == 3'b110 && (i[12:11] == 2'b10 || i[12:11] == 2'b00)) ||
               (i[15:13] == 3'b101);
    endfunction

    task automatic check(input string tag, input out_t e);
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Expected output per cycle after the accepting edge, from the instruction's semantics.
    task automatic build_trace(input logic [15:0] i);
        logic [15:0] sx;
        bit mov_reg, mvn, cmp, unary;
        out_t e;
        sx      = {{8{i[7]}}, i[7:0]};
        mov_reg = (i[15:11] == 5'b11000);
        mvn     = (i[15:11] == 5'b10111);
        cmp     = (i[15:11] == 5'b10101);
        unary   = mov_reg || mvn;
        exp_q.delete();
        exp_q.push_back(blank(sx));
        if (i[15:11] == 5'b11010) begin
            e = blank(sx); e.write = 1'b1; e.writenum = i[10:8]; e.vsel = 2'b10;
            exp_q.push_back(e);
        end else if (is_legal(i)) begin
            if (!unary) begin
                e = blank(sx); e.readnum = i[10:8]; e.loada = 1'b1;
                exp_q.push_back(e);
            end
            e = blank(sx); e.readnum = i[2:0]; e.loadb = 1'b1;
            exp_q.push_back(e);
            e = blank(sx); e.shift = i[4:3]; e.aluop = mov_reg ? 2'b00 : i[12:11];
            e.asel = unary;
            if (cmp) e.loads = 1'b1;
            else     e.loadc = 1'b1;
            exp_q.push_back(e);
            if (!cmp) begin
                e = blank(sx); e.writenum = i[7:5]; e.write = 1'b1;
                exp_q.push_back(e);
            end
        end else begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
            for (int k = 0; k < 4; k++) begin
                e = blank(sx); e.err = 1'b1;
                exp_q.push_back(e);
            end
`endif
        end
    endtask

    // Called at a negedge in WAIT; returns at the negedge after the trace ends.
    task automatic run_instr(input string tag, input logic [15:0] i, input logic [15:0] nxt,
                             input bit hold);
        check({tag, "_idle"}, idle(cur_sx));
        s  = 1'b1;
        in = i;
        @(negedge clk);
        cur_sx = {{8{i[7]}}, i[7:0]};
        build_trace(i);
        s  = hold ? 1'b1 : 1'($urandom_range(0, 1));
        in = hold ? nxt : 16'($urandom);
        foreach (exp_q[k]) begin
            check($sformatf("%s_c%0d", tag, k), exp_q[k]);
            @(negedge clk);
        end
        if (!hold) s = 1'b0;
    endtask

    task automatic reset_cycle(input string tag, input logic [15:0] next_i);
        #1 reset = 1'b1;
        #1 check({tag, "_async"}, idle(16'h0000));
        cur_sx = 16'h0000;
        @(negedge clk);
        check({tag, "_held"}, idle(16'h0000));
        s  = 1'b1;
        in = next_i;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check({tag, "_s_ignored"}, idle(16'h0000));
    endtask

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        in    = 16'h0000;
        cur_sx = 16'h0000;
        @(negedge clk);
        check("reset_state", idle(16'h0000));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        run_instr("mov_imm_r0", 16'hD02A, 16'h0000, 1'b0);
        run_instr("mov_imm_neg", 16'hD1FF, 16'h0000, 1'b0);
        run_instr("add", 16'hA148, 16'h0000, 1'b0);
        run_instr("cmp_hold", 16'hA900, 16'hC00A, 1'b1);
        run_instr("mov_reg_hold", 16'hC00A, 16'hB871, 1'b1);
        run_instr("mvn", 16'hB871, 16'h0000, 1'b0);
        run_instr("and", 16'hB285, 16'h0000, 1'b0);

        // Reset while an ADD sits in GET_B.
        check("add2_idle", idle(cur_sx));
        s  = 1'b1;
        in = 16'hA148;
        @(negedge clk);
        cur_sx = 16'h0048;
        build_trace(16'hA148);
        s = 1'b0;
        check("add2_decode", exp_q[0]);
        @(negedge clk);
        check("add2_get_a", exp_q[1]);
        @(negedge clk);
        check("add2_get_b", exp_q[2]);
        reset_cycle("rst_mid", 16'hD1FF);
        run_instr("mov_after_rst", 16'hD1FF, 16'h0000, 1'b0);

        for (int k = 0; k < 41; k++) begin
            logic [15:0] v;
            v = 16'($urandom);
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
            while (!is_legal(v)) v = 16'($urandom);
`else
            if (k % 7 == 3) begin
                while (is_legal(v)) v = 16'($urandom);
            end else begin
                while (!is_legal(v)) v = 16'($urandom);
            end
`endif
            rnd[k] = v;
        end
        for (int k = 0; k < 40; k++) begin
            run_instr($sformatf("rnd%0d", k), rnd[k], rnd[k+1], 1'($urandom_range(0, 1)));
        end
        s = 1'b0;
        @(negedge clk);

        run_instr("illegal", 16'hE000, 16'h0000, 1'b0);
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
        begin
            out_t e;
            e = blank(16'h0000); e.err = 1'b1;
            check("halt_sticky", e);
        end
`else
        check("illegal_back_to_wait", idle(16'h0000));
`endif
        reset_cycle("rst_end", 16'hD02A);
        run_instr("mov_final", 16'hD02A, 16'h0000, 1'b0);
        check("final_idle", idle(16'h002A));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
